// File: rtl/gm_port_arbiter_if.sv
// rtl/gm_port_arbiter_if.sv - requester and gen_m0 bridge signal bundle for gm_port_arbiter
// Purpose: groups the two-requester command/response port and the gen_m0 generic-master port.
// Ports (slave = arbiter view):
//   rq_*       requester commands, write beats and accept pulses
//   rs_*       read responses routed back to requesters
//   gen_m0_m*  command/write-data side toward the bridge
//   gen_m0_s*  accept/response side from the bridge
//   err_sticky response seen for a requester with no outstanding reads
interface gm_port_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 512
);
    logic [1:0]        rq_read;
    logic [1:0]        rq_write;
    logic [2*AW-1:0]   rq_addr;
    logic [15:0]       rq_len;
    logic [5:0]        rq_size;
    logic [2*DW-1:0]   rq_data;
    logic [2*DW/8-1:0] rq_wstrb;
    logic [1:0]        rq_accept;
    logic [1:0]        rs_valid;
    logic [1:0]        rs_last;
    logic [DW-1:0]     rs_data;
    logic [2:0]        rs_resp;
    logic [1:0]        rs_ready;

    logic [AW-1:0]     gen_m0_maddr;
    logic [7:0]        gen_m0_mlen;
    logic [2:0]        gen_m0_msize;
    logic [DW-1:0]     gen_m0_mdata;
    logic [DW/8-1:0]   gen_m0_mwstrb;
    logic              gen_m0_mread;
    logic              gen_m0_mwrite;
    logic              gen_m0_mlock;
    logic [1:0]        gen_m0_mburst;
    logic [3:0]        gen_m0_mcache;
    logic [2:0]        gen_m0_mprot;
    logic              gen_m0_mid;
    logic              gen_m0_mready;
    logic              gen_m0_saccept;
    logic              gen_m0_svalid;
    logic              gen_m0_slast;
    logic              gen_m0_sid;
    logic [DW-1:0]     gen_m0_sdata;
    logic [2:0]        gen_m0_sresp;
    logic              err_sticky;

    modport slave (
        input  rq_read, rq_write, rq_addr, rq_len, rq_size, rq_data, rq_wstrb, rs_ready,
        input  gen_m0_saccept, gen_m0_svalid, gen_m0_slast, gen_m0_sid, gen_m0_sdata, gen_m0_sresp,
        output rq_accept, rs_valid, rs_last, rs_data, rs_resp,
        output gen_m0_maddr, gen_m0_mlen, gen_m0_msize, gen_m0_mdata, gen_m0_mwstrb,
        output gen_m0_mread, gen_m0_mwrite, gen_m0_mlock, gen_m0_mburst, gen_m0_mcache,
        output gen_m0_mprot, gen_m0_mid, gen_m0_mready, err_sticky
    );

    modport master (
        output rq_read, rq_write, rq_addr, rq_len, rq_size, rq_data, rq_wstrb, rs_ready,
        output gen_m0_saccept, gen_m0_svalid, gen_m0_slast, gen_m0_sid, gen_m0_sdata, gen_m0_sresp,
        input  rq_accept, rs_valid, rs_last, rs_data, rs_resp,
        input  gen_m0_maddr, gen_m0_mlen, gen_m0_msize, gen_m0_mdata, gen_m0_mwstrb,
        input  gen_m0_mread, gen_m0_mwrite, gen_m0_mlock, gen_m0_mburst, gen_m0_mcache,
        input  gen_m0_mprot, gen_m0_mid, gen_m0_mready, err_sticky
    );
endinterface

// File: rtl/gm_port_arbiter.sv
// rtl/gm_port_arbiter.sv - two-requester round-robin arbiter for the gen_m0 generic-master port
// Purpose: shares gen_m0 between req 0 and req 1 at command granularity; write bursts hold the
//          grant until their last beat, read responses are steered by sid, and per-requester
//          outstanding-read counters throttle read issue.
// Ports:
//   ap_clk    clock
//   ap_rst_n  synchronous active-low reset
//   bus       gm_port_arbiter_if.slave (requester side + gen_m0 side + err_sticky)
module gm_port_arbiter #(
    parameter int AW        = 64,
    parameter int DW        = 512,
    parameter int MAX_OUTST = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    gm_port_arbiter_if.slave     bus
);
    localparam logic [7:0] LP_MAX = 8'(MAX_OUTST);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t          r_state;
    logic            r_grant;
    logic            r_rr;
    logic            r_mread;
    logic            r_mwrite;
    logic            r_err;
    logic [7:0]      r_beat;
    logic [7:0]      r_outst [2];
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_len;
    logic [2:0]      r_size;

    logic [1:0]      w_elig;
    logic            w_pick;
    logic            w_any;
    logic            w_cmd_acc;
    logic            w_beat_acc;
    logic            w_rsp_done;
    logic [1:0]      w_inc;
    logic [1:0]      w_dec;

    // Writes are never throttled; reads stop being eligible once the requester hits its limit.
    always_comb begin
        w_elig = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_elig[i] = bus.rq_write[i] | (bus.rq_read[i] & (r_outst[i] < LP_MAX));
        end
    end

    assign w_any      = |w_elig;
    assign w_pick     = w_elig[r_rr] ? r_rr : ~r_rr;
    assign w_cmd_acc  = (r_state == S_RD) & bus.gen_m0_saccept;
    assign w_beat_acc = (r_state == S_WR) & bus.gen_m0_saccept;
    assign w_rsp_done = bus.gen_m0_svalid & bus.gen_m0_mready & bus.gen_m0_slast;

    always_comb begin
        w_inc = 2'b00;
        w_dec = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_inc[i] = w_cmd_acc & (r_grant == 1'(i));
            w_dec[i] = w_rsp_done & (bus.gen_m0_sid == 1'(i));
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b0;
            r_rr       <= 1'b0;
            r_mread    <= 1'b0;
            r_mwrite   <= 1'b0;
            r_err      <= 1'b0;
            r_beat     <= 8'd0;
            r_outst[0] <= 8'd0;
            r_outst[1] <= 8'd0;
            r_addr     <= '0;
            r_len      <= 8'd0;
            r_size     <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_addr  <= bus.rq_addr[int'(w_pick)*AW +: AW];
                        r_len   <= bus.rq_len[int'(w_pick)*8 +: 8];
                        r_size  <= bus.rq_size[int'(w_pick)*3 +: 3];
                        if (bus.rq_write[w_pick]) begin
                            r_state  <= S_WR;
                            r_mwrite <= 1'b1;
                        end else begin
                            r_state  <= S_RD;
                            r_mread  <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (bus.gen_m0_saccept) begin
                        r_mread <= 1'b0;
                        r_rr    <= ~r_grant;
                        r_state <= S_IDLE;
                    end
                end
                S_WR: begin
                    if (bus.gen_m0_saccept) begin
                        if (r_beat == r_len) begin
                            r_beat   <= 8'd0;
                            r_mwrite <= 1'b0;
                            r_rr     <= ~r_grant;
                            r_state  <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mread  <= 1'b0;
                    r_mwrite <= 1'b0;
                end
            endcase

            // Simultaneous issue and completion on one requester cancel out.
            for (int i = 0; i < 2; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_outst[i] <= r_outst[i] + 8'd1;
                end else if (w_dec[i] && !w_inc[i]) begin
                    if (r_outst[i] == 8'd0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_outst[i] <= r_outst[i] - 8'd1;
                    end
                end
            end
        end
    end

    assign bus.rq_accept     = (w_cmd_acc | w_beat_acc) ? (2'b01 << r_grant) : 2'b00;
    assign bus.gen_m0_maddr  = r_addr;
    assign bus.gen_m0_mlen   = r_len;
    assign bus.gen_m0_msize  = r_size;
    assign bus.gen_m0_mdata  = bus.rq_data[int'(r_grant)*DW +: DW];
    assign bus.gen_m0_mwstrb = bus.rq_wstrb[int'(r_grant)*(DW/8) +: (DW/8)];
    assign bus.gen_m0_mread  = r_mread;
    assign bus.gen_m0_mwrite = r_mwrite;
    assign bus.gen_m0_mlock  = 1'b0;
    assign bus.gen_m0_mburst = 2'b01;
    assign bus.gen_m0_mcache = 4'b0011;
    assign bus.gen_m0_mprot  = 3'b000;
    assign bus.gen_m0_mid    = r_grant;
    assign bus.err_sticky    = r_err;

    // Response path is purely combinational, steered by sid.
    assign bus.gen_m0_mready = bus.rs_ready[bus.gen_m0_sid];
    assign bus.rs_valid      = bus.gen_m0_svalid ? (2'b01 << bus.gen_m0_sid) : 2'b00;
    assign bus.rs_last       = bus.gen_m0_slast ? (2'b01 << bus.gen_m0_sid) : 2'b00;
    assign bus.rs_data       = bus.gen_m0_sdata;
    assign bus.rs_resp       = bus.gen_m0_sresp;
endmodule

// File: tb/tb_gm_port_arbiter.sv
// tb/tb_gm_port_arbiter.sv - directed self-checking bench for gm_port_arbiter
module tb_gm_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 512;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cnt;

    gm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    gm_port_arbiter #(.AW(AW), .DW(DW), .MAX_OUTST(8)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge ap_clk);
        #1;
    endtask

    task automatic send_rsp(input logic sid);
        bus.gen_m0_svalid = 1'b1;
        bus.gen_m0_slast  = 1'b1;
        bus.gen_m0_sid    = sid;
        tick();
        bus.gen_m0_svalid = 1'b0;
        bus.gen_m0_slast  = 1'b0;
    endtask

    initial begin
        bus.rq_read        = 2'b00;
        bus.rq_write       = 2'b00;
        bus.rq_addr        = {64'h2000, 64'h1000};
        bus.rq_len         = {8'd3, 8'd3};
        bus.rq_size        = {3'd6, 3'd6};
        bus.rq_data        = '0;
        bus.rq_wstrb       = '1;
        bus.rs_ready       = 2'b11;
        bus.gen_m0_saccept = 1'b1;
        bus.gen_m0_svalid  = 1'b0;
        bus.gen_m0_slast   = 1'b0;
        bus.gen_m0_sid     = 1'b0;
        bus.gen_m0_sdata   = '0;
        bus.gen_m0_sresp   = 3'd0;

        // Reset state
        repeat (2) tick();
        check("rst_mread",  64'(bus.gen_m0_mread),  64'd0);
        check("rst_mwrite", 64'(bus.gen_m0_mwrite), 64'd0);
        check("rst_accept", 64'(bus.rq_accept),     64'd0);
        check("rst_err",    64'(bus.err_sticky),    64'd0);
        ap_rst_n    = 1'b1;
        bus.rq_read = 2'b11;

        // Both requesters reading: mid 0,1,0,1 with an idle cycle between commands
        for (int j = 0; j < 8; j++) begin
            tick();
            check($sformatf("alt_mread_%0d", j), 64'(bus.gen_m0_mread), 64'((j % 2) == 0));
            if ((j % 2) == 0) begin
                check($sformatf("alt_mid_%0d", j),    64'(bus.gen_m0_mid), 64'((j / 2) % 2));
                check($sformatf("alt_accept_%0d", j), 64'(bus.rq_accept),  64'(1 << ((j / 2) % 2)));
                check($sformatf("alt_addr_%0d", j),   bus.gen_m0_maddr,    ((j / 2) % 2) ? 64'h2000 : 64'h1000);
            end
            if (j == 7) bus.rq_read = 2'b00;
        end

        // Responses routed by sid
        for (int k = 0; k < 4; k++) begin
            bus.gen_m0_svalid = 1'b1;
            bus.gen_m0_slast  = 1'b1;
            bus.gen_m0_sid    = 1'(k / 2);
            bus.gen_m0_sdata  = DW'(100 + k);
            tick();
            check($sformatf("rsp_valid_%0d", k), 64'(bus.rs_valid),       64'(1 << (k / 2)));
            check($sformatf("rsp_data_%0d", k),  bus.rs_data[63:0],       64'(100 + k));
            check($sformatf("rsp_mready_%0d", k), 64'(bus.gen_m0_mready), 64'd1);
        end
        bus.gen_m0_svalid = 1'b0;
        bus.gen_m0_slast  = 1'b0;
        tick();
        check("rsp_err", 64'(bus.err_sticky), 64'd0);

        // Req1 write burst len=7, req0 read raised mid-burst must wait
        bus.rq_len   = {8'd7, 8'd3};
        bus.rq_write = 2'b10;
        for (int j = 0; j < 8; j++) begin
            tick();
            check($sformatf("wr_mwrite_%0d", j), 64'(bus.gen_m0_mwrite), 64'd1);
            check($sformatf("wr_mread_%0d", j),  64'(bus.gen_m0_mread),  64'd0);
            check($sformatf("wr_mid_%0d", j),    64'(bus.gen_m0_mid),    64'd1);
            check($sformatf("wr_accept_%0d", j), 64'(bus.rq_accept),     64'b10);
            check($sformatf("wr_data_%0d", j),   bus.gen_m0_mdata[63:0], 64'(j));
            bus.rq_data[DW +: DW] = DW'(j + 1);
            if (j == 1) bus.rq_read = 2'b01;
            if (j == 7) bus.rq_write = 2'b00;
        end
        tick();
        check("wr_gap_mwrite", 64'(bus.gen_m0_mwrite), 64'd0);
        check("wr_gap_mread",  64'(bus.gen_m0_mread),  64'd0);
        tick();
        check("wr_after_mread",  64'(bus.gen_m0_mread), 64'd1);
        check("wr_after_mid",    64'(bus.gen_m0_mid),   64'd0);
        check("wr_after_accept", 64'(bus.rq_accept),    64'b01);
        bus.rq_read = 2'b00;
        send_rsp(1'b0);

        // Throttle: req0 gets exactly 8 reads, then only after a response
        bus.rq_read = 2'b01;
        cnt = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (bus.rq_accept[0]) cnt++;
            if (j == 15) begin
                bus.rq_write = 2'b10;
                bus.rq_len   = {8'd0, 8'd3};
            end
        end
        check("thr_reads", 64'(cnt), 64'd8);
        tick();
        check("thr_wr_mwrite", 64'(bus.gen_m0_mwrite), 64'd1);
        check("thr_wr_accept", 64'(bus.rq_accept),     64'b10);
        bus.rq_write = 2'b00;
        tick();
        check("thr_idle1", 64'(bus.gen_m0_mread), 64'd0);
        tick();
        check("thr_idle2", 64'(bus.gen_m0_mread), 64'd0);
        bus.gen_m0_svalid = 1'b1;
        bus.gen_m0_slast  = 1'b1;
        bus.gen_m0_sid    = 1'b0;
        tick();
        check("thr_idle3", 64'(bus.gen_m0_mread), 64'd0);
        bus.gen_m0_svalid = 1'b0;
        bus.gen_m0_slast  = 1'b0;
        tick();
        check("thr_9th_mread",  64'(bus.gen_m0_mread), 64'd1);
        check("thr_9th_mid",    64'(bus.gen_m0_mid),   64'd0);
        check("thr_9th_accept", 64'(bus.rq_accept),    64'b01);
        bus.rq_read = 2'b10;

        // One req1 read, then its response back-pressured by rs_ready[1]
        tick();
        tick();
        check("bp_rd_mid",    64'(bus.gen_m0_mid), 64'd1);
        check("bp_rd_accept", 64'(bus.rq_accept),  64'b10);
        bus.rq_read       = 2'b00;
        bus.gen_m0_svalid = 1'b1;
        bus.gen_m0_slast  = 1'b1;
        bus.gen_m0_sid    = 1'b1;
        bus.gen_m0_sdata  = DW'(64'hABCD);
        bus.rs_ready      = 2'b01;
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("bp_mready_%0d", j), 64'(bus.gen_m0_mready), 64'd0);
            check($sformatf("bp_valid_%0d", j),  64'(bus.rs_valid),      64'b10);
            check($sformatf("bp_last_%0d", j),   64'(bus.rs_last),       64'b10);
            check($sformatf("bp_data_%0d", j),   bus.rs_data[63:0],      64'hABCD);
        end
        bus.rs_ready = 2'b11;
        tick();
        check("bp_mready_go", 64'(bus.gen_m0_mready), 64'd1);
        bus.gen_m0_svalid = 1'b0;
        bus.gen_m0_slast  = 1'b0;
        tick();
        check("bp_err", 64'(bus.err_sticky), 64'd0);

        // Drain req0's 8 reads, then one extra response sets err_sticky
        for (int k = 0; k < 8; k++) send_rsp(1'b0);
        tick();
        check("drain_err", 64'(bus.err_sticky), 64'd0);
        send_rsp(1'b0);
        tick();
        check("under_err", 64'(bus.err_sticky), 64'd1);
        tick();
        check("under_err_sticky", 64'(bus.err_sticky), 64'd1);

        // Reset during beat 3 of an 8-beat write
        bus.rq_len   = {8'd7, 8'd0};
        bus.rq_write = 2'b10;
        tick();
        check("rstwr_b0", 64'(bus.gen_m0_mwrite), 64'd1);
        tick();
        tick();
        check("rstwr_b2_accept", 64'(bus.rq_accept), 64'b10);
        ap_rst_n     = 1'b0;
        bus.rq_write = 2'b00;
        bus.rq_read  = 2'b11;
        tick();
        check("rstwr_mwrite", 64'(bus.gen_m0_mwrite), 64'd0);
        check("rstwr_mread",  64'(bus.gen_m0_mread),  64'd0);
        check("rstwr_accept", 64'(bus.rq_accept),     64'd0);
        check("rstwr_err",    64'(bus.err_sticky),    64'd0);
        ap_rst_n = 1'b1;
        tick();
        check("rstwr_rd_mread", 64'(bus.gen_m0_mread), 64'd1);
        check("rstwr_rd_mid",   64'(bus.gen_m0_mid),   64'd0);
        bus.rq_read = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
